vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 H_VISIBLE, 640, active pixels per line.
REQ-002 H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in clocks; line total is 800.
REQ-003 V_VISIBLE, 480, active lines per frame.
REQ-004 V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical porch and sync widths in lines; frame total is 525.
REQ-005 clk25  in  1  pixel clock, 25 MHz; the only clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 red_in, green_in, blue_in  in  4 each  pixel colour from the game stage for the current xpos/ypos.
REQ-008 test_sel  in  1  selects the built-in test pattern; used only under the configuration macro.
REQ-009 xpos  out  10  horizontal counter, 0..799.
REQ-010 ypos  out  10  vertical counter, 0..524.
REQ-011 frame_start  out  1  one-clock pulse while xpos==0 and ypos==0.
REQ-012 vga_r, vga_g, vga_b  out  4 each  registered colour to the DAC.
REQ-013 vga_hs, vga_vs  out  1 each  registered sync outputs, active-low.

Function
REQ-014 xpos SHALL increment every clk25 and wrap from 799 to 0.
REQ-015 ypos SHALL increment only in the cycle where xpos wraps, and SHALL wrap from 524 to 0 in that same cycle.
REQ-016 xpos and ypos SHALL be flop outputs with no combinational path from any input.
REQ-017 visible SHALL be defined as xpos<640 && ypos<480 (the internal value in the current cycle).
REQ-018 hs_raw SHALL be 0 for xpos in 656..751 and 1 otherwise; vs_raw SHALL be 0 for ypos in 490..491 and 1 otherwise.
REQ-019 vga_hs, vga_vs, and the colour outputs SHALL be registered from the same-cycle xpos/ypos/visible/colour, giving exactly 1 clock of latency for every output, so sync and colour stay aligned.
REQ-020 When visible was 0, vga_r/g/b SHALL register 0 regardless of the colour inputs.
REQ-021 When visible was 1 and the test pattern is not active, vga_r/g/b SHALL register red_in/green_in/blue_in unmodified.
REQ-022 frame_start SHALL be combinational from the counters and SHALL be high exactly one clock per 420000 clocks.
REQ-023 The counter arithmetic SHALL be 10-bit unsigned, and no intermediate value SHALL exceed the wrap limits.
REQ-024 Counter sequencing SHALL NOT depend on any input other than reset.

Reset
REQ-025 While reset is high: xpos=0, ypos=0, vga_r/g/b=0, vga_hs=1, vga_vs=1.
REQ-026 On the first clock after reset falls, xpos=1 and ypos=0; frame_start SHALL be high during the reset-exit cycle (xpos=0, ypos=0).
REQ-027 Reset asserted mid-frame SHALL restart timing at 0,0 on the next edge, with no partial sync pulse held low.

Configuration
REQ-028 Macro VGA_TEST_PATTERN_EN: when defined and test_sel=1, visible pixels SHALL output 8 vertical bars, each 80 px wide, with idx=xpos/80: vga_r={4{idx[2]}}, vga_g={4{idx[1]}}, vga_b={4{idx[0]}}.
REQ-029 Without VGA_TEST_PATTERN_EN, test_sel SHALL be ignored and no pattern logic SHALL be synthesised.
REQ-030 Under either setting, blanking (REQ-020) SHALL take priority over the test pattern.

Structure
REQ-031 Package vga_pkg SHALL hold all timing constants: the visible, porch, and sync widths, the totals, and the derived sync start/end values.
REQ-032 Sub-module vga_counter SHALL be a parameterised modulo-N counter with an enable input and a wrap output, instantiated once for horizontal and once for vertical (vertical enabled by the horizontal wrap).

Verification
REQ-033 Release reset, then count 800 clocks: xpos returns to 0; ypos=1; vga_hs low for exactly 96 clocks, starting 1 clock after xpos=656.
REQ-034 Run 420000 clocks: frame_start pulses exactly once; vga_vs low for exactly 1600 clocks (2 lines), starting 1 clock after xpos=0, ypos=490.
REQ-035 Hold red_in=F, green_in=A, blue_in=5: outputs are F/A/5 one clock after visible pixels; outputs are 0 one clock after xpos=640 and for all ypos>=480.
REQ-036 Assert reset at xpos=700, ypos=491: next edge gives xpos=0, ypos=0, vga_hs=1, vga_vs=1, rgb=0.
REQ-037 With VGA_TEST_PATTERN_EN and test_sel=1: at xpos=0 the output is 0/0/0; at xpos=80 it is 0/0/F; at xpos=560 it is F/F/F; at xpos=639 it is F/F/F; at xpos=640 it is 0.
REQ-038 Without the macro and with test_sel=1: outputs equal the colour inputs.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants shared by the counter and the top level.
// Optional feature macro: VGA_TEST_PATTERN_EN (enables the colour-bar helper).
package vga_pkg;

  localparam int unsigned CNT_W = 32'd10;

  // Horizontal timing, in pixel clocks.
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;  // first column after sync

  // Vertical timing, in lines.
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;  // first line after sync

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'd80;

  // Index of the 80-pixel colour bar containing column x (valid for x < 640).
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    return 3'(x / BAR_W);
  endfunction
`endif

endpackage

// File: rtl/vga_counter.sv
// Modulo-N up counter with enable; wrap is high in the cycle that returns to 0.
module vga_counter #(
  parameter int unsigned W = 32'd10,
  parameter logic [W-1:0] N = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = N - {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;
  logic         wrap_s;

  assign wrap_s = en && (count_r == LAST);
  assign wrap   = wrap_s;
  assign count  = count_r;

  // Count register: cleared by reset, folds back to 0 instead of reaching N.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (wrap_s) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator with registered sync and colour outputs.
// Optional feature macro: VGA_TEST_PATTERN_EN (test_sel selects 8 colour bars).
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk25,
  input  logic       reset,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  input  logic       test_sel,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       frame_start,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs
);

  logic [9:0] xpos_s;
  logic [9:0] ypos_s;
  logic       h_wrap_s;
  logic       v_wrap_unused_s;
  logic       visible_s;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic [3:0] r_s;
  logic [3:0] g_s;
  logic [3:0] b_s;
  logic [3:0] vga_r_r;
  logic [3:0] vga_g_r;
  logic [3:0] vga_b_r;
  logic       vga_hs_r;
  logic       vga_vs_r;

  vga_counter #(.W(CNT_W), .N(H_TOTAL)) u_hcnt (
    .clk   (clk25),
    .reset (reset),
    .en    (1'b1),
    .count (xpos_s),
    .wrap  (h_wrap_s)
  );

  vga_counter #(.W(CNT_W), .N(V_TOTAL)) u_vcnt (
    .clk   (clk25),
    .reset (reset),
    .en    (h_wrap_s),
    .count (ypos_s),
    .wrap  (v_wrap_unused_s)
  );

  assign xpos        = xpos_s;
  assign ypos        = ypos_s;
  assign frame_start = (xpos_s == 10'd0) && (ypos_s == 10'd0);
  assign visible_s   = (xpos_s < H_VISIBLE) && (ypos_s < V_VISIBLE);
  assign hs_raw_s    = !((xpos_s >= H_SYNC_START) && (xpos_s < H_SYNC_END));
  assign vs_raw_s    = !((ypos_s >= V_SYNC_START) && (ypos_s < V_SYNC_END));

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_s;

  // Pixel colour: blank outside the visible area, else bars or game colour.
  always_comb begin
    r_s   = 4'd0;
    g_s   = 4'd0;
    b_s   = 4'd0;
    bar_s = bar_index(xpos_s);
    if (visible_s) begin
      if (test_sel) begin
        r_s = {4{bar_s[2]}};
        g_s = {4{bar_s[1]}};
        b_s = {4{bar_s[0]}};
      end else begin
        r_s = red_in;
        g_s = green_in;
        b_s = blue_in;
      end
    end else begin
      r_s = 4'd0;
      g_s = 4'd0;
      b_s = 4'd0;
    end
  end
`else
  logic unused_test_sel_s;
  assign unused_test_sel_s = test_sel;

  // Pixel colour: blank outside the visible area, else the game colour.
  always_comb begin
    r_s = 4'd0;
    g_s = 4'd0;
    b_s = 4'd0;
    if (visible_s) begin
      r_s = red_in;
      g_s = green_in;
      b_s = blue_in;
    end else begin
      r_s = 4'd0;
      g_s = 4'd0;
      b_s = 4'd0;
    end
  end
`endif

  // Output stage: one clock of latency for sync and colour so they stay aligned.
  always_ff @(posedge clk25) begin
    if (reset) begin
      vga_r_r  <= 4'd0;
      vga_g_r  <= 4'd0;
      vga_b_r  <= 4'd0;
      vga_hs_r <= 1'b1;
      vga_vs_r <= 1'b1;
    end else begin
      vga_r_r  <= r_s;
      vga_g_r  <= g_s;
      vga_b_r  <= b_s;
      vga_hs_r <= hs_raw_s;
      vga_vs_r <= vs_raw_s;
    end
  end

  assign vga_r  = vga_r_r;
  assign vga_g  = vga_g_r;
  assign vga_b  = vga_b_r;
  assign vga_hs = vga_hs_r;
  assign vga_vs = vga_vs_r;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a reference model pushes the expected
// registered outputs into a queue each cycle; they are popped after the edge.
// Honours VGA_TEST_PATTERN_EN the same way as the design build.
module tb_vga_timing;

  logic       clk25;
  logic       reset;
  logic [3:0] red_in;
  logic [3:0] green_in;
  logic [3:0] blue_in;
  logic       test_sel;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       frame_start;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;

  vga_timing dut (
    .clk25       (clk25),
    .reset       (reset),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .test_sel    (test_sel),
    .xpos        (xpos),
    .ypos        (ypos),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs)
  );

  // 25 MHz pixel clock.
  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_pass   = 0;
  int mx = 0;
  int my = 0;
  logic [13:0] exp_q[$];

  bit track_hs   = 1'b0;
  int hs_low     = 0;
  int hs_first_x = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (model x=%0d y=%0d)", tag, got, exp, mx, my);
    end
  endtask

  // Expected {r,g,b,hs,vs} registered from position (x,y) and the inputs.
  function automatic logic [13:0] model_out(input int x, input int y, input logic [3:0] r,
                                            input logic [3:0] g, input logic [3:0] b,
                                            input logic ts);
    logic       vis;
    logic       hs;
    logic       vs;
    logic [2:0] idx;
    logic [11:0] rgb;
    vis = (x < 640) && (y < 480);
    hs  = !((x >= 656) && (x <= 751));
    vs  = !((y >= 490) && (y <= 491));
    idx = 3'(x / 80);
    rgb = 12'd0;
    if (vis) begin
      rgb = {r, g, b};
`ifdef VGA_TEST_PATTERN_EN
      if (ts) rgb = {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
`else
      if (ts) rgb = {r, g, b};
`endif
    end
    return {rgb, hs, vs};
  endfunction

  // One clock: drive inputs, push expectation, advance the model, compare after the edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic ts);
    logic [13:0] got;
    reset    = rst;
    red_in   = r;
    green_in = g;
    blue_in  = b;
    test_sel = ts;
    if (rst) exp_q.push_back({12'd0, 2'b11});
    else     exp_q.push_back(model_out(mx, my, r, g, b, ts));
    if (rst) begin
      mx = 0;
      my = 0;
    end else if (mx == 799) begin
      mx = 0;
      my = (my == 524) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    @(posedge clk25);
    #1;
    got = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
    check("rgb_sync", {18'd0, got}, {18'd0, exp_q.pop_front()});
    check("xpos", {22'd0, xpos}, mx);
    check("ypos", {22'd0, ypos}, my);
    check("frame_start", {31'd0, frame_start}, {31'd0, (mx == 0) && (my == 0)});
    if (track_hs && !vga_hs) begin
      if (hs_low == 0) hs_first_x = int'(xpos);
      hs_low++;
    end
  endtask

  task automatic step_rand(input logic ts);
    step(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)), ts);
  endtask

  initial begin
    reset = 1'b1; red_in = 4'd0; green_in = 4'd0; blue_in = 4'd0; test_sel = 1'b0;

    // Reset held with busy colour inputs: outputs must stay blank, syncs high.
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'hF, 4'hF, 1'b0);
    check("reset_fs", {31'd0, frame_start}, 32'd1);

    // First line after release: random colours, measure the hsync pulse.
    track_hs = 1'b1;
    for (int i = 0; i < 800; i++) step_rand(1'b0);
    track_hs = 1'b0;
    check("line_wrap_x", {22'd0, xpos}, 32'd0);
    check("line_wrap_y", {22'd0, ypos}, 32'd1);
    check("hs_low_len", hs_low, 32'd96);
    check("hs_first_x", hs_first_x, 32'd657);

    // Fixed F/A/5 with test_sel low, then high (bars or passthrough by build).
    for (int i = 0; i < 1600; i++) step(1'b0, 4'hF, 4'hA, 4'h5, 1'b0);
    for (int i = 0; i < 1600; i++) step(1'b0, 4'hF, 4'hA, 4'h5, 1'b1);

    // Random colours and random test_sel toggling over many lines.
    for (int i = 0; i < 12000; i++) step_rand(1'($urandom_range(1)));

    // Mid-line reset at xpos=700 (inside hsync): must restart cleanly at 0,0.
    while (mx != 700) step_rand(1'b0);
    check("pre_reset_hs", {31'd0, vga_hs}, 32'd0);
    step(1'b1, 4'hF, 4'hA, 4'h5, 1'b0);
    check("mid_reset_x", {22'd0, xpos}, 32'd0);
    check("mid_reset_y", {22'd0, ypos}, 32'd0);
    check("mid_reset_hs", {31'd0, vga_hs}, 32'd1);
    check("mid_reset_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);

    // Continue for over a line after the restart.
    for (int i = 0; i < 1000; i++) step_rand(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
